ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
- Parametrised successor to the CPU control-unit Moore FSM: sequences fetch, decode, execute, PC-increment, halt and interrupt entry for the simple CPU.
- Adds a configurable number of functional classes and multi-cycle execute with a per-instruction cycle count.
- Adds a fetch timeout with a sticky fault state, an illegal-class trap, interrupt entry, and halt/resume.
- Sits between the instruction decoder and the datapath/memory interface. All control outputs are Moore-decoded from the registered state.

Parameters:
- NUM_FUNC, 4, number of legal functional classes (2..16). FUNC_W = max(1, clog2(NUM_FUNC)), derived.
- EXEC_CYC_W, 4, width of the per-instruction execute cycle count.
- MEM_TIMEOUT, 16, maximum FETCH cycles waiting for mem_rdy before a fault (2..256).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; sampled in IDLE and INCPC only.
- func  in  FUNC_W  functional class from the decoder; sampled in DECODE.
- exec_cycles  in  EXEC_CYC_W  execute length in cycles; sampled in DECODE.
- mem_rdy  in  1  instruction memory ready; sampled in FETCH.
- halt  in  1  decoded halt instruction; sampled in DECODE.
- irq  in  1  interrupt request, level; sampled in INCPC and HALT.
- resume  in  1  leave HALT; sampled in HALT.
- state  out  4  encoded current state.
- func_sel  out  FUNC_W  class latched at DECODE; valid during EXEC.
- exec_active  out  1  high in EXEC.
- pc_inc  out  1  high in INCPC.
- pc_load  out  1  high in IRQ (load vector).
- irq_ack  out  1  high in IRQ.
- fault  out  1  high in FAULT.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; fetch counter=0; exec counter=0; func_sel=0; all 1-bit outputs 0.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, INCPC=4, IRQ=5, HALT=6, FAULT=7. Codes 8..15 unused; any unused code goes to FAULT on the next clock.
- Every case branch assigns next_state; the default is hold. No latches.
- IDLE: en=1 -> FETCH; else hold.
- FETCH: fetch counter increments each cycle it stays in FETCH and is cleared on entry.
  - mem_rdy=1 -> DECODE.
  - Counter == MEM_TIMEOUT-1 and mem_rdy=0 -> FAULT.
  - mem_rdy=1 on the timeout cycle wins (goes to DECODE).
- DECODE: priority is halt, then illegal class, then normal.
  - halt=1 -> HALT.
  - func >= NUM_FUNC -> FAULT.
  - Otherwise: func_sel<=func; exec counter<=exec_cycles, with 0 loaded as 1; -> EXEC.
- EXEC: counter decrements each cycle. At counter==1 -> INCPC. EXEC therefore lasts exactly max(1, exec_cycles) cycles.
- INCPC: single cycle.
  - irq=1 -> IRQ.
  - Else en=1 -> FETCH.
  - Else -> IDLE.
- IRQ: single cycle; irq_ack=1, pc_load=1 -> FETCH.
- HALT: irq=1 -> IRQ (irq beats resume); else resume=1 -> INCPC (PC advances past the halt); else hold.
- FAULT: sticky; fault=1 until rst asserts.
- Minimum instruction latency: 3 + max(1, exec_cycles) cycles (FETCH 1, DECODE 1, EXEC n, INCPC 1) when mem_rdy is already high.
- func_sel holds its value outside EXEC; it updates only in DECODE on a legal class.
- Reset mid-instruction returns to IDLE immediately, regardless of state or counters.
- en=0 during FETCH/DECODE/EXEC does not abort; the instruction completes and the block drops to IDLE at INCPC.
- Counter widths: fetch counter clog2(MEM_TIMEOUT) bits, no wrap possible; exec counter EXEC_CYC_W bits.

Decomposition:
- Package ctrl_seq_pkg: state encoding localparams (S_IDLE..S_FAULT), STATE_W=4, and a clog2 function.
- Sub-module ctrl_cycle_counter (loadable down-counter with a terminal-count flag, width parameter). It is used for the exec counter; the fetch timeout uses an instance in up-count mode or inline logic.
- Output decode stays in the top module.

Test Plan:
- Reset/enable: rst=0 then 1, en=0 for 5 cycles -> state=0, all outputs 0. en=1 -> state=1 on the next clock.
- Normal instruction: mem_rdy=1, func=2, exec_cycles=3 -> state sequence 1,2,3,3,3,4,1. func_sel=2 during EXEC; pc_inc high 1 cycle.
- Zero-length and illegal class:
  - exec_cycles=0 -> exactly 1 EXEC cycle.
  - With NUM_FUNC=3, func=3 at DECODE -> state=7, fault=1 and held for 20 cycles.
- Fetch timeout (MEM_TIMEOUT=16):
  - mem_rdy low for 16 FETCH cycles -> FAULT.
  - Separate run: mem_rdy asserted on the 16th cycle -> DECODE, no fault.
- Halt and interrupt:
  - halt=1 at DECODE -> HALT held 10 cycles.
  - irq=1 and resume=1 together -> IRQ with irq_ack=pc_load=1 for 1 cycle, then FETCH.
  - resume alone -> INCPC then FETCH.
- Async reset mid-EXEC (exec_cycles=8, reset at the 4th EXEC cycle, between clock edges) -> state=0 immediately. After release with en=1 -> FETCH on the next clock.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_seq_pkg
// Purpose : shared definitions for the control sequencer: state encoding,
//           state width and a constant-evaluable ceil(log2) helper.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package ctrl_seq_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE   = 4'd0;
  localparam logic [STATE_W-1:0] S_FETCH  = 4'd1;
  localparam logic [STATE_W-1:0] S_DECODE = 4'd2;
  localparam logic [STATE_W-1:0] S_EXEC   = 4'd3;
  localparam logic [STATE_W-1:0] S_INCPC  = 4'd4;
  localparam logic [STATE_W-1:0] S_IRQ    = 4'd5;
  localparam logic [STATE_W-1:0] S_HALT   = 4'd6;
  localparam logic [STATE_W-1:0] S_FAULT  = 4'd7;

  // Codes 8..15 are deliberately left out of the enum; the FSM maps any of
  // them to FAULT.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = S_IDLE,
    ST_FETCH  = S_FETCH,
    ST_DECODE = S_DECODE,
    ST_EXEC   = S_EXEC,
    ST_INCPC  = S_INCPC,
    ST_IRQ    = S_IRQ,
    ST_HALT   = S_HALT,
    ST_FAULT  = S_FAULT
  } state_e;

  // ceil(log2(value)) for value >= 1; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ctrl_cycle_counter.sv
// ---------------------------------------------------------------------------
// ctrl_cycle_counter
// Purpose : loadable up/down cycle counter with a terminal-count flag.
//           Priority: clear, then load, then step.
// Ports   :
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous active-low reset (count -> 0)
//   clr_i      in  synchronous clear to 0
//   load_i     in  load load_val_i
//   load_val_i in  WIDTH value to load
//   step_i     in  count one step (up when UP=1, else down)
//   tc_o       out count currently equals TC_VAL
// ---------------------------------------------------------------------------
module ctrl_cycle_counter #(
  parameter int unsigned      WIDTH  = 4,
  parameter bit               UP     = 1'b0,
  parameter logic [WIDTH-1:0] TC_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (step_i) begin
      count_d = UP ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
// Purpose : CPU control sequencer. Steps FETCH -> DECODE -> EXEC(n) -> INCPC,
//           with fetch timeout (sticky FAULT), illegal-class trap, interrupt
//           entry and halt/resume. Control outputs are Moore-decoded and
//           registered alongside the state.
// Ports   :
//   clk            in  clock, rising edge
//   rst_n          in  asynchronous active-low reset
//   en_i           in  run enable (IDLE, INCPC)
//   func_i         in  functional class from decoder (DECODE)
//   exec_cycles_i  in  execute length in cycles, 0 treated as 1 (DECODE)
//   mem_rdy_i      in  instruction memory ready (FETCH)
//   halt_i         in  decoded halt (DECODE)
//   irq_i          in  interrupt request, level (INCPC, HALT)
//   resume_i       in  leave HALT (HALT)
//   state_o        out encoded current state
//   func_sel_o     out class latched in DECODE, valid during EXEC
//   exec_active_o  out high in EXEC
//   pc_inc_o       out high in INCPC
//   pc_load_o      out high in IRQ
//   irq_ack_o      out high in IRQ
//   fault_o        out high in FAULT
// ---------------------------------------------------------------------------
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter  int unsigned NUM_FUNC    = 4,
  parameter  int unsigned EXEC_CYC_W  = 4,
  parameter  int unsigned MEM_TIMEOUT = 16,
  localparam int unsigned FUNC_W      = (clog2(NUM_FUNC) < 1) ? 1 : clog2(NUM_FUNC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [FUNC_W-1:0]     func_i,
  input  logic [EXEC_CYC_W-1:0] exec_cycles_i,
  input  logic                  mem_rdy_i,
  input  logic                  halt_i,
  input  logic                  irq_i,
  input  logic                  resume_i,
  output logic [STATE_W-1:0]    state_o,
  output logic [FUNC_W-1:0]     func_sel_o,
  output logic                  exec_active_o,
  output logic                  pc_inc_o,
  output logic                  pc_load_o,
  output logic                  irq_ack_o,
  output logic                  fault_o
);

  localparam int unsigned FETCH_W =
    (clog2(MEM_TIMEOUT) < 1) ? 1 : clog2(MEM_TIMEOUT);
  // One extra bit so NUM_FUNC itself is representable for the legality test.
  localparam logic [FUNC_W:0] NUM_FUNC_EXT = (FUNC_W + 1)'(NUM_FUNC);

  state_e state_q;
  state_e state_d;

  logic [FUNC_W-1:0] func_sel_q;
  logic              exec_active_q;
  logic              pc_inc_q;
  logic              pc_load_q;
  logic              irq_ack_q;
  logic              fault_q;

  logic                  illegal_func;
  logic                  exec_load;
  logic [EXEC_CYC_W-1:0] exec_load_val;
  logic                  exec_tc;
  logic                  fetch_tc;

  assign illegal_func  = ({1'b0, func_i} >= NUM_FUNC_EXT);
  assign exec_load     = (state_q == ST_DECODE) && !halt_i && !illegal_func;
  assign exec_load_val = (exec_cycles_i == '0) ? EXEC_CYC_W'(1) : exec_cycles_i;

  // Execute length: loaded with n in DECODE, counts down in EXEC, and the
  // last EXEC cycle is the one where the count reads 1.
  ctrl_cycle_counter #(
    .WIDTH  (EXEC_CYC_W),
    .UP     (1'b0),
    .TC_VAL (EXEC_CYC_W'(1))
  ) u_exec_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (1'b0),
    .load_i     (exec_load),
    .load_val_i (exec_load_val),
    .step_i     (state_q == ST_EXEC),
    .tc_o       (exec_tc)
  );

  // Fetch wait: held at 0 outside FETCH so the first FETCH cycle reads 0;
  // the MEM_TIMEOUT-th FETCH cycle raises the terminal flag. FETCH is always
  // left at that point, so the counter never wraps.
  ctrl_cycle_counter #(
    .WIDTH  (FETCH_W),
    .UP     (1'b1),
    .TC_VAL (FETCH_W'(MEM_TIMEOUT - 1))
  ) u_fetch_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_q != ST_FETCH),
    .load_i     (1'b0),
    .load_val_i ('0),
    .step_i     (state_q == ST_FETCH),
    .tc_o       (fetch_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = en_i ? ST_FETCH : ST_IDLE;
      ST_FETCH: begin
        // mem_rdy wins over the timeout on the same cycle.
        if (mem_rdy_i)     state_d = ST_DECODE;
        else if (fetch_tc) state_d = ST_FAULT;
        else               state_d = ST_FETCH;
      end
      ST_DECODE: begin
        if (halt_i)            state_d = ST_HALT;
        else if (illegal_func) state_d = ST_FAULT;
        else                   state_d = ST_EXEC;
      end
      ST_EXEC:   state_d = exec_tc ? ST_INCPC : ST_EXEC;
      ST_INCPC: begin
        if (irq_i)     state_d = ST_IRQ;
        else if (en_i) state_d = ST_FETCH;
        else           state_d = ST_IDLE;
      end
      ST_IRQ:    state_d = ST_FETCH;
      ST_HALT: begin
        if (irq_i)         state_d = ST_IRQ;
        else if (resume_i) state_d = ST_INCPC;
        else               state_d = ST_HALT;
      end
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  // Outputs are decoded from the next state and registered with it, so they
  // are a pure function of the registered state as seen from outside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      func_sel_q    <= '0;
      exec_active_q <= 1'b0;
      pc_inc_q      <= 1'b0;
      pc_load_q     <= 1'b0;
      irq_ack_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (exec_load) begin
        func_sel_q  <= func_i;
      end
      exec_active_q <= (state_d == ST_EXEC);
      pc_inc_q      <= (state_d == ST_INCPC);
      pc_load_q     <= (state_d == ST_IRQ);
      irq_ack_q     <= (state_d == ST_IRQ);
      fault_q       <= (state_d == ST_FAULT);
    end
  end

  assign state_o       = state_q;
  assign func_sel_o    = func_sel_q;
  assign exec_active_o = exec_active_q;
  assign pc_inc_o      = pc_inc_q;
  assign pc_load_o     = pc_load_q;
  assign irq_ack_o     = irq_ack_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ctrl_sequencer
// Purpose : self-checking bench for ctrl_sequencer (NUM_FUNC=3,
//           EXEC_CYC_W=4, MEM_TIMEOUT=16). Each instruction is described by
//           its fetch wait, class, execute length and exit choices; the
//           expected per-cycle state trace follows from that description.
//           Inputs the current state does not sample are randomised.
// ---------------------------------------------------------------------------
module tb_ctrl_sequencer;

  localparam int NF = 3;
  localparam int EW = 4;
  localparam int MT = 16;
  localparam int FW = 2;

  localparam int T_IDLE   = 0;
  localparam int T_FETCH  = 1;
  localparam int T_DECODE = 2;
  localparam int T_EXEC   = 3;
  localparam int T_INCPC  = 4;
  localparam int T_IRQ    = 5;
  localparam int T_HALT   = 6;
  localparam int T_FAULT  = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_i;
  logic [FW-1:0] func_i;
  logic [EW-1:0] exec_cycles_i;
  logic          mem_rdy_i;
  logic          halt_i;
  logic          irq_i;
  logic          resume_i;
  logic [3:0]    state_o;
  logic [FW-1:0] func_sel_o;
  logic          exec_active_o;
  logic          pc_inc_o;
  logic          pc_load_o;
  logic          irq_ack_o;
  logic          fault_o;

  int checks    = 0;
  int errors    = 0;
  int last_func = 0;

  always #5 clk = ~clk;

  ctrl_sequencer #(
    .NUM_FUNC    (NF),
    .EXEC_CYC_W  (EW),
    .MEM_TIMEOUT (MT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en_i),
    .func_i        (func_i),
    .exec_cycles_i (exec_cycles_i),
    .mem_rdy_i     (mem_rdy_i),
    .halt_i        (halt_i),
    .irq_i         (irq_i),
    .resume_i      (resume_i),
    .state_o       (state_o),
    .func_sel_o    (func_sel_o),
    .exec_active_o (exec_active_o),
    .pc_inc_o      (pc_inc_o),
    .pc_load_o     (pc_load_o),
    .irq_ack_o     (irq_ack_o),
    .fault_o       (fault_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {exec_active, pc_inc, pc_load, irq_ack, fault} for a given state
  function automatic logic [4:0] exp_outs(input int s);
    return {s == T_EXEC, s == T_INCPC, s == T_IRQ, s == T_IRQ, s == T_FAULT};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    en_i          = 1'($urandom);
    func_i        = FW'($urandom);
    exec_cycles_i = EW'($urandom);
    mem_rdy_i     = 1'($urandom);
    halt_i        = 1'($urandom);
    irq_i         = 1'($urandom);
    resume_i      = 1'($urandom);
  endtask

  task automatic expect_state(input string tag, input int s);
    check({tag, "_state"}, 32'(state_o), s);
    check({tag, "_outs"},
          32'({exec_active_o, pc_inc_o, pc_load_o, irq_ack_o, fault_o}),
          32'(exp_outs(s)));
    check({tag, "_fsel"}, 32'(func_sel_o), last_func);
  endtask

  // Precondition: DUT is in FETCH. Postcondition: DUT has just entered FETCH.
  // w    : FETCH cycles with mem_rdy low before it rises (0..MT-1)
  // hold : HALT cycles with neither irq nor resume
  // hact : HALT exit, 1 = irq and resume together, else resume only
  // act  : INCPC exit, 1 = irq, 2 = drop to IDLE, else en=1
  task automatic run_instr(input int w, input int f, input int n, input bit do_halt,
                           input int hold, input int hact, input int act);
    int ncyc;
    $display("instr wait=%0d func=%0d cycles=%0d halt=%0d hold=%0d hact=%0d act=%0d",
             w, f, n, do_halt, hold, hact, act);
    for (int k = 0; k <= w; k++) begin
      expect_state("fetch", T_FETCH);
      rand_inputs();
      mem_rdy_i = (k == w);
      tick();
    end
    expect_state("decode", T_DECODE);
    rand_inputs();
    halt_i        = do_halt;
    func_i        = FW'(f);
    exec_cycles_i = EW'(n);
    tick();
    if (do_halt) begin
      for (int k = 0; k < hold; k++) begin
        expect_state("halt_hold", T_HALT);
        rand_inputs();
        irq_i    = 1'b0;
        resume_i = 1'b0;
        tick();
      end
      expect_state("halt_exit", T_HALT);
      rand_inputs();
      if (hact == 1) begin
        irq_i    = 1'b1;
        resume_i = 1'b1;
        tick();
        expect_state("halt_irq", T_IRQ);
        rand_inputs();
        tick();
        return;
      end
      irq_i    = 1'b0;
      resume_i = 1'b1;
      tick();
    end else begin
      last_func = f;
      ncyc = (n == 0) ? 1 : n;
      for (int k = 0; k < ncyc; k++) begin
        expect_state("exec", T_EXEC);
        rand_inputs();
        tick();
      end
    end
    expect_state("incpc", T_INCPC);
    rand_inputs();
    case (act)
      1:       irq_i = 1'b1;
      2:       begin irq_i = 1'b0; en_i = 1'b0; end
      default: begin irq_i = 1'b0; en_i = 1'b1; end
    endcase
    tick();
    if (act == 1) begin
      expect_state("irq", T_IRQ);
      rand_inputs();
      tick();
    end else if (act == 2) begin
      for (int k = 0; k < 2; k++) begin
        expect_state("idle", T_IDLE);
        rand_inputs();
        en_i = 1'b0;
        tick();
      end
      expect_state("idle", T_IDLE);
      rand_inputs();
      en_i = 1'b1;
      tick();
    end
  endtask

  // Called just after a rising edge: asserts reset between edges, checks the
  // immediate return to IDLE, releases with en=1 so FETCH follows next edge.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    last_func = 0;
    expect_state("async_rst", T_IDLE);
    rand_inputs();
    en_i  = 1'b1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    en_i          = 1'b0;
    func_i        = '0;
    exec_cycles_i = '0;
    mem_rdy_i     = 1'b0;
    halt_i        = 1'b0;
    irq_i         = 1'b0;
    resume_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_state("reset", T_IDLE);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_state("idle_en0", T_IDLE);
      rand_inputs();
      en_i = 1'b0;
    end
    en_i = 1'b1;
    tick();

    // directed instructions
    run_instr(0,      2, 3, 1'b0, 0,  0, 0);  // 1,2,3,3,3,4,1
    run_instr(0,      1, 0, 1'b0, 0,  0, 0);  // zero-length execute
    run_instr(MT - 1, 0, 5, 1'b0, 0,  0, 0);  // mem_rdy on the timeout cycle
    run_instr(1,      0, 2, 1'b1, 10, 1, 0);  // halt held, irq beats resume
    run_instr(0,      2, 1, 1'b1, 2,  0, 0);  // resume alone
    run_instr(0,      1, 15, 1'b0, 0, 0, 1);  // irq at INCPC
    run_instr(2,      2, 4, 1'b0, 0,  0, 2);  // drop to IDLE

    // randomised instructions
    for (int i = 0; i < 40; i++) begin
      run_instr(($urandom_range(0, 7) == 0) ? (MT - 1) : int'($urandom_range(0, 3)),
                int'($urandom_range(0, NF - 1)),
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)));
    end

    // fetch timeout: MT FETCH cycles without mem_rdy -> sticky FAULT
    $display("fetch timeout");
    for (int k = 0; k < MT; k++) begin
      expect_state("fetch_to", T_FETCH);
      rand_inputs();
      mem_rdy_i = 1'b0;
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      expect_state("fault_to", T_FAULT);
      rand_inputs();
      tick();
    end

    // reset mid-EXEC (4th cycle of an 8-cycle execute)
    $display("reset mid-exec");
    async_reset();
    expect_state("mid_fetch", T_FETCH);
    rand_inputs();
    mem_rdy_i = 1'b1;
    tick();
    expect_state("mid_decode", T_DECODE);
    rand_inputs();
    halt_i        = 1'b0;
    func_i        = FW'(1);
    exec_cycles_i = EW'(8);
    tick();
    last_func = 1;
    for (int k = 0; k < 4; k++) begin
      expect_state("mid_exec", T_EXEC);
      if (k < 3) begin
        rand_inputs();
        tick();
      end
    end
    async_reset();

    // illegal class -> sticky FAULT
    $display("illegal class");
    expect_state("ill_fetch", T_FETCH);
    rand_inputs();
    mem_rdy_i = 1'b1;
    tick();
    expect_state("ill_decode", T_DECODE);
    rand_inputs();
    halt_i = 1'b0;
    func_i = FW'(3);
    tick();
    for (int k = 0; k < 20; k++) begin
      expect_state("fault_ill", T_FAULT);
      rand_inputs();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
